// File: rtl/param_ram_pkg.sv
// Shared types and defaults for the parameterised RAM.
// The clear/idle state encoding lives here so every user agrees on it.
package param_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 8;

endpackage

// File: rtl/param_ram_word.sv
// One storage word of param_ram: a WIDTH-bit register with load enable.
// Holds its value until ld is asserted.
module param_word
    import param_ram_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (ld) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/param_ram.sv
// Word-addressed RAM with registered read and a self-clearing sweep
// that zeroes one word per cycle after reset or a clr request.
module param_ram
    import param_ram_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             w,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] d_in,
    input  logic             r,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] d_out,
    output logic             rd_valid,
    input  logic             clr,
    output logic             busy
);

    localparam logic [AW:0] SP_LAST = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] SP_ONE  = (AW+1)'(1);

    state_e           state_q, state_d;
    logic [AW:0]      sp_q, sp_d;
    logic [WIDTH-1:0] d_out_q, d_out_d;
    logic             rd_valid_q, rd_valid_d;

    logic             we;
    logic             re;
    logic             sweep;
    logic [DEPTH-1:0] word_ld;
    logic [WIDTH-1:0] word_d;
    logic [WIDTH-1:0] rdata;
    logic [WIDTH-1:0] mem [DEPTH];

    always_comb begin
        state_d    = state_q;
        sp_d       = sp_q;
        d_out_d    = d_out_q;
        rd_valid_d = 1'b0;
        we         = 1'b0;
        re         = 1'b0;
        if (rst) begin
            state_d = CLEAR;
            sp_d    = '0;
            d_out_d = '0;
        end else begin
            unique case (state_q)
                CLEAR: begin
                    sp_d = sp_q + SP_ONE;
                    if (sp_q == SP_LAST) begin
                        state_d = IDLE;
                        sp_d    = '0;
                    end
                end
                IDLE: begin
                    if (clr) begin
                        state_d = CLEAR;
                        sp_d    = '0;
                    end else begin
                        we = en & w;
                        re = en & r;
                        if (re) begin
                            d_out_d = rdata;
                        end
                        rd_valid_d = re;
                    end
                end
            endcase
        end
    end

    // Same-address read sees the incoming write data (write-first).
    assign rdata = (en && w && (waddr == raddr)) ? d_in : mem[raddr];

    assign sweep  = !rst && (state_q == CLEAR);
    assign word_d = sweep ? '0 : d_in;

    always_comb begin
        word_ld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            word_ld[i] = (sweep && (sp_q[AW-1:0] == AW'(i)))
                       || (we && (waddr == AW'(i)));
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        param_word #(
            .WIDTH(WIDTH)
        ) u_word (
            .clk(clk),
            .ld (word_ld[g]),
            .d  (word_d),
            .q  (mem[g])
        );
    end

    always_ff @(posedge clk) begin
        state_q    <= state_d;
        sp_q       <= sp_d;
        d_out_q    <= d_out_d;
        rd_valid_q <= rd_valid_d;
    end

    assign d_out    = d_out_q;
    assign rd_valid = rd_valid_q;
    assign busy     = (state_q == CLEAR);

endmodule

// File: tb/tb_param_ram.sv
// Self-checking bench for param_ram against a word-array reference model.
// Directed scenarios followed by a randomized soak.
module tb_param_ram;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int AW = 3;

    logic          clk;
    logic          rst;
    logic          en;
    logic          w;
    logic [AW-1:0] waddr;
    logic [W-1:0]  d_in;
    logic          r;
    logic [AW-1:0] raddr;
    logic [W-1:0]  d_out;
    logic          rd_valid;
    logic          clr;
    logic          busy;

    int n_cmp;
    int n_bad;

    logic [W-1:0] mm [D];
    int           busy_left;
    logic [W-1:0] e_dout;
    logic         e_valid;

    param_ram #(
        .WIDTH(W),
        .DEPTH(D)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .w       (w),
        .waddr   (waddr),
        .d_in    (d_in),
        .r       (r),
        .raddr   (raddr),
        .d_out   (d_out),
        .rd_valid(rd_valid),
        .clr     (clr),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a clear wipes the whole array and makes the RAM
    // unavailable for D cycles; otherwise a plain write-first RAM.
    task automatic tick(input logic rst_i, input logic en_i,
                        input logic w_i, input logic [AW-1:0] wa,
                        input logic [W-1:0] di, input logic r_i,
                        input logic [AW-1:0] ra, input logic clr_i);
        rst = rst_i; en = en_i; w = w_i; waddr = wa;
        d_in = di; r = r_i; raddr = ra; clr = clr_i;
        @(posedge clk);
        if (rst_i) begin
            busy_left = D;
            for (int i = 0; i < D; i++) mm[i] = '0;
            e_valid = 1'b0;
            e_dout  = '0;
        end else if (busy_left > 0) begin
            busy_left = busy_left - 1;
            e_valid   = 1'b0;
        end else if (clr_i) begin
            busy_left = D;
            for (int i = 0; i < D; i++) mm[i] = '0;
            e_valid = 1'b0;
        end else begin
            e_valid = en_i & r_i;
            if (en_i && r_i) begin
                e_dout = (en_i && w_i && wa == ra) ? di : mm[ra];
            end
            if (en_i && w_i) mm[wa] = di;
        end
        #1;
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] v);
        tick(1'b0, 1'b1, 1'b1, a, v, 1'b0, '0, 1'b0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        tick(1'b0, 1'b1, 1'b0, '0, '0, 1'b1, a, 1'b0);
    endtask

    task automatic test_reset();
        int n;
        tick(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        n_cmp++;
        if (busy !== 1'b1 || rd_valid !== 1'b0 || d_out !== '0) begin
            n_bad++;
            $display("FAIL reset_state busy=%b rdv=%b dout=%h need 1 0 0",
                     busy, rd_valid, d_out);
        end
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            idle();
        end
        n_cmp++;
        if (n != D) begin
            n_bad++;
            $display("FAIL reset_busy_len got %0d need %0d", n, D);
        end
        for (int a = 0; a < D; a++) begin
            rd(AW'(a));
            n_cmp++;
            if (rd_valid !== 1'b1 || d_out !== 16'h0000) begin
                n_bad++;
                $display("FAIL reset_read a=%0d rdv=%b dout=%h need 1 0000",
                         a, rd_valid, d_out);
            end
            idle();
            n_cmp++;
            if (rd_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_read_pulse a=%0d rdv=%b need 0",
                         a, rd_valid);
            end
        end
    endtask

    task automatic test_write_read();
        wr(3'd3, 16'hA5A5);
        n_cmp++;
        if (rd_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_no_valid rdv=%b need 0", rd_valid);
        end
        rd(3'd3);
        n_cmp++;
        if (rd_valid !== 1'b1 || d_out !== 16'hA5A5) begin
            n_bad++;
            $display("FAIL write_read rdv=%b dout=%h need 1 a5a5",
                     rd_valid, d_out);
        end
        idle();
        n_cmp++;
        if (d_out !== 16'hA5A5 || rd_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL dout_hold dout=%h rdv=%b need a5a5 0",
                     d_out, rd_valid);
        end
    endtask

    task automatic test_same_cycle();
        wr(3'd6, 16'h6666);
        tick(1'b0, 1'b1, 1'b1, 3'd5, 16'h1234, 1'b1, 3'd5, 1'b0);
        n_cmp++;
        if (rd_valid !== 1'b1 || d_out !== 16'h1234) begin
            n_bad++;
            $display("FAIL write_first rdv=%b dout=%h need 1 1234",
                     rd_valid, d_out);
        end
        tick(1'b0, 1'b1, 1'b1, 3'd2, 16'hBEEF, 1'b1, 3'd6, 1'b0);
        n_cmp++;
        if (rd_valid !== 1'b1 || d_out !== 16'h6666) begin
            n_bad++;
            $display("FAIL diff_addr_read rdv=%b dout=%h need 1 6666",
                     rd_valid, d_out);
        end
        rd(3'd2);
        n_cmp++;
        if (d_out !== 16'hBEEF) begin
            n_bad++;
            $display("FAIL diff_addr_write dout=%h need beef", d_out);
        end
    endtask

    task automatic test_clr_drop();
        int n;
        for (int a = 0; a < D; a++) wr(AW'(a), W'($urandom));
        tick(1'b0, 1'b1, 1'b1, 3'd1, 16'hFFFF, 1'b1, 3'd1, 1'b1);
        n_cmp++;
        if (busy !== 1'b1 || rd_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_start busy=%b rdv=%b need 1 0",
                     busy, rd_valid);
        end
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick(1'b0, 1'b1, 1'b1, 3'd1, 16'hFFFF, 1'b1, 3'd1, 1'b1);
            if (busy === 1'b0) break;
        end
        n_cmp++;
        if (n != D) begin
            n_bad++;
            $display("FAIL clr_busy_len got %0d need %0d", n, D);
        end
        idle();
        for (int a = 0; a < D; a++) begin
            rd(AW'(a));
            n_cmp++;
            if (rd_valid !== 1'b1 || d_out !== '0) begin
                n_bad++;
                $display("FAIL clr_read a=%0d rdv=%b dout=%h need 1 0000",
                         a, rd_valid, d_out);
            end
        end
    endtask

    task automatic test_rst_mid();
        int n;
        tick(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
        repeat (4) idle();
        tick(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            idle();
        end
        n_cmp++;
        if (n != D) begin
            n_bad++;
            $display("FAIL rst_mid_sweep_len got %0d need %0d", n, D);
        end
        wr(3'd4, 16'h4444);
        rd(3'd4);
        tick(1'b1, 1'b1, 1'b0, '0, '0, 1'b1, 3'd4, 1'b0);
        n_cmp++;
        if (rd_valid !== 1'b0 || d_out !== '0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_read rdv=%b dout=%h busy=%b need 0 0 1",
                     rd_valid, d_out, busy);
        end
        repeat (D) idle();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_read_done busy=%b need 0", busy);
        end
    endtask

    task automatic test_en_gate();
        wr(3'd4, 16'hC0DE);
        tick(1'b0, 1'b0, 1'b1, 3'd4, 16'h1111, 1'b1, 3'd4, 1'b0);
        n_cmp++;
        if (rd_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL en_block_read rdv=%b need 0", rd_valid);
        end
        rd(3'd4);
        n_cmp++;
        if (d_out !== 16'hC0DE) begin
            n_bad++;
            $display("FAIL en_block_write dout=%h need c0de", d_out);
        end
        tick(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL en_clr busy=%b need 1", busy);
        end
        repeat (D) idle();
        rd(3'd4);
        n_cmp++;
        if (d_out !== '0 || rd_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL en_clr_read dout=%h rdv=%b need 0000 1",
                     d_out, rd_valid);
        end
    endtask

    task automatic test_random();
        logic e_busy;
        for (int k = 0; k < 400; k++) begin
            tick(($urandom % 70) == 0, ($urandom % 4) != 0,
                 1'($urandom), AW'($urandom), W'($urandom),
                 1'($urandom), AW'($urandom), ($urandom % 30) == 0);
            e_busy = (busy_left > 0);
            n_cmp++;
            if (busy !== e_busy || rd_valid !== e_valid
                || d_out !== e_dout) begin
                n_bad++;
                $display("FAIL random k=%0d busy=%b rdv=%b dout=%h need %b %b %h",
                         k, busy, rd_valid, d_out, e_busy, e_valid, e_dout);
            end
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        busy_left = 0;
        e_dout    = '0;
        e_valid   = 1'b0;
        for (int i = 0; i < D; i++) mm[i] = '0;
        rst = 1'b0; en = 1'b0; w = 1'b0; waddr = '0;
        d_in = '0; r = 1'b0; raddr = '0; clr = 1'b0;
        test_reset();
        test_write_read();
        test_same_cycle();
        test_clr_drop();
        test_rst_mid();
        test_en_gate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
